// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch slice.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit and imem.
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC priority select (jalr > branch > sequential) and alignment check.
// With PC_MISALIGN_TRAP_EN the raw selection is passed through so the
// caller can trap; otherwise the low two bits are cleared.
module pc_next_mux
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] pc_branch,
    input  logic [31:0] jalr_target,
    input  logic        branch_taken,
    input  logic        jalr_taken,
    output logic [31:0] next_pc,
    output logic        next_misaligned
);

    logic [31:0] sel_pc;

    // Priority select of the redirect target.
    always_comb begin
        sel_pc = pc_plus_4;
        if (jalr_taken) begin
            sel_pc = jalr_target;
        end else if (branch_taken) begin
            sel_pc = pc_branch;
        end
    end

    // Flag misalignment and, in the default build, force word alignment.
    always_comb begin
        next_misaligned = |sel_pc[1:0];
`ifdef PC_MISALIGN_TRAP_EN
        next_pc = sel_pc;
`else
        next_pc = sel_pc & PC_ALIGN_MASK;
`endif
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and instruction fetch over a req/ack bus.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds sticky misalign_trap).
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            pc_plus_4,
    input  logic [31:0]            pc_branch,
    input  logic                   branch_taken,
    input  logic                   jalr_taken,
    input  logic [31:0]            jalr_target,
    input  logic                   stall,
    input  logic                   halt,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            pc_current,
    output logic [31:0]            instr,
    output logic                   instr_valid,
`ifdef PC_MISALIGN_TRAP_EN
    output logic                   misalign_trap,
`endif
    output logic                   halted
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  next_pc;
    logic         next_misaligned;
    logic         retire;
    logic         trap_take;
    logic         req_o;

    pc_next_mux u_next_mux (
        .pc_plus_4       (pc_plus_4),
        .pc_branch       (pc_branch),
        .jalr_target     (jalr_target),
        .branch_taken    (branch_taken),
        .jalr_taken      (jalr_taken),
        .next_pc         (next_pc),
        .next_misaligned (next_misaligned)
    );

    assign retire = (state_q == HOLD) && !stall;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap_take = retire && next_misaligned;
`else
    assign trap_take = 1'b0;

    // The default build must never present a misaligned fetch address.
    always_comb begin
        assert (!(next_misaligned && (next_pc[1:0] != 2'b00)));
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; REQ ignores halt/stall/redirects.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = halt ? HALTED : REQ;
            REQ:     state_d = imem.imem_ack ? HOLD : REQ;
            HOLD: begin
                if (!stall) begin
                    state_d = (halt || trap_take) ? HALTED : REQ;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; reset forces IDLE so req drops asynchronously.
    always_comb begin
        req_o       = (state_q == REQ);
        instr_valid = (state_q == HOLD);
        halted      = (state_q == HALTED);
    end

    assign imem.imem_req  = req_o;
    assign imem.imem_addr = pc_current;

    // PC, captured instruction and sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_current <= RESET_VECTOR;
            instr      <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            if ((state_q == REQ) && imem.imem_ack) begin
                instr <= imem.imem_rdata;
            end
            if (retire && !trap_take) begin
                pc_current <= next_pc;
            end
`ifdef PC_MISALIGN_TRAP_EN
            if (trap_take) begin
                misalign_trap <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a transaction-level expectation model.
// Honours PC_MISALIGN_TRAP_EN when defined.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_plus_4, pc_branch, jalr_target;
    logic        branch_taken, jalr_taken, stall, halt;
    logic [31:0] pc_current, instr;
    logic        instr_valid, halted;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    pc_fetch_unit_if imem_bus ();

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_plus_4    (pc_plus_4),
        .pc_branch    (pc_branch),
        .branch_taken (branch_taken),
        .jalr_taken   (jalr_taken),
        .jalr_target  (jalr_target),
        .stall        (stall),
        .halt         (halt),
        .imem         (imem_bus.master),
        .pc_current   (pc_current),
        .instr        (instr),
        .instr_valid  (instr_valid),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .halted       (halted)
    );

    int checks   = 0;
    int failures = 0;

    // Expected architectural view, advanced by the stimulus tasks.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_req, exp_valid, exp_halted, exp_trap;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p4, input logic [31:0] pbr,
                                               input logic br, input logic jt,
                                               input logic [31:0] jtgt);
        logic [31:0] t;
        if (jt)      t = jtgt;
        else if (br) t = pbr;
        else         t = p4;
`ifndef PC_MISALIGN_TRAP_EN
        t = {t[31:2], 2'b00};
`endif
        return t;
    endfunction

    // Compare DUT against the expectation every cycle, away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pc_current", pc_current, exp_pc);
            chk("imem_addr", imem_bus.imem_addr, exp_pc);
            chk("imem_req", 32'(imem_bus.imem_req), 32'(exp_req));
            chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
            chk("halted", 32'(halted), 32'(exp_halted));
            if (exp_valid) chk("instr", instr, exp_instr);
`ifdef PC_MISALIGN_TRAP_EN
            chk("misalign_trap", 32'(misalign_trap), 32'(exp_trap));
`endif
        end
    end

    task automatic clear_inputs();
        pc_plus_4 = '0; pc_branch = '0; jalr_target = '0;
        branch_taken = 1'b0; jalr_taken = 1'b0; stall = 1'b0; halt = 1'b0;
    endtask

    task automatic set_reset_exp();
        exp_pc = 32'h0; exp_req = 1'b0; exp_valid = 1'b0;
        exp_halted = 1'b0; exp_trap = 1'b0; exp_instr = '0;
    endtask

    // Hold reset two edges, check reset values, release mid-cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        set_reset_exp();
        #1;
        chk("rst_pc", pc_current, 32'h0);
        chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_req = 1'b1;
        chk("first_req", 32'(imem_bus.imem_req), 32'h1);
    endtask

    // Called in REQ: wait `delay` cycles with noise on ignored inputs, then ack.
    task automatic do_fetch(input int unsigned delay);
        halt = 1'b1; stall = 1'b1; branch_taken = 1'b1; jalr_taken = 1'b1;
        pc_branch = 32'h0000_0007; jalr_target = 32'h0000_0003;
        for (int unsigned i = 0; i < delay; i++) begin
            imem_bus.imem_ack = 1'b0;
            imem_bus.imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = mem_word(exp_pc);
        @(posedge clk); #1;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = $urandom;
        clear_inputs();
        exp_req = 1'b0; exp_valid = 1'b1; exp_instr = mem_word(exp_pc);
    endtask

    // Called in HOLD: release the instruction with the given redirect inputs.
    task automatic retire(input logic [31:0] p4, input logic [31:0] pbr, input logic br,
                          input logic jt, input logic [31:0] jtgt, input logic h);
        logic [31:0] n;
        logic        mis;
        pc_plus_4 = p4; pc_branch = pbr; branch_taken = br;
        jalr_taken = jt; jalr_target = jtgt; halt = h; stall = 1'b0;
        n = model_next(p4, pbr, br, jt, jtgt);
        mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis = (n[1:0] != 2'b00);
`endif
        @(posedge clk); #1;
        clear_inputs();
        exp_valid = 1'b0;
        if (mis) begin
            exp_trap = 1'b1; exp_halted = 1'b1;
        end else begin
            exp_pc = n;
            if (h) exp_halted = 1'b1;
            else   exp_req = 1'b1;
        end
    endtask

    initial begin
        clear_inputs();
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = '0;
        set_reset_exp();
        rst_n = 1'b0;
        mon_en = 1'b1;
        apply_reset();

        // Sequential flow 0, 4, 8 with same-cycle ack.
        chk("seq_addr0", imem_bus.imem_addr, 32'h0);
        do_fetch(0);
        chk("seq_instr0", instr, 32'h0000_0013);
        retire(32'h4, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("seq_addr1", imem_bus.imem_addr, 32'h4);
        do_fetch(0);
        retire(32'h8, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("seq_addr2", imem_bus.imem_addr, 32'h8);
        do_fetch(0);

        // Branch, then jalr beating branch.
        retire(32'h20, '0, 1'b0, 1'b0, '0, 1'b0);
        do_fetch(0);
        chk("pc_at_20", pc_current, 32'h20);
        retire(32'h24, 32'h10, 1'b1, 1'b0, '0, 1'b0);
        chk("branch_addr", imem_bus.imem_addr, 32'h10);
        do_fetch(0);
        retire(32'h14, 32'h30, 1'b1, 1'b1, 32'h100, 1'b0);
        chk("jalr_prio_addr", imem_bus.imem_addr, 32'h100);
        do_fetch(0);

        // Stall for three cycles in HOLD.
        stall = 1'b1;
        pc_plus_4 = 32'h4000; branch_taken = 1'b1; pc_branch = 32'h8000;
        repeat (3) begin @(posedge clk); #1; end
        chk("stall_instr", instr, mem_word(32'h100));
        chk("stall_pc", pc_current, 32'h100);
        retire(32'h104, '0, 1'b0, 1'b0, '0, 1'b0);

        // Slow memory: ack after four cycles.
        do_fetch(4);
        chk("slow_instr", instr, mem_word(32'h104));

        // Wrap from the top of the address space.
        retire(32'hFFFF_FFFC, '0, 1'b0, 1'b0, '0, 1'b0);
        do_fetch(0);
        retire(32'h0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("wrap_addr", imem_bus.imem_addr, 32'h0);

        // Reset while a fetch is outstanding and an ack is in flight.
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        set_reset_exp();
        #1;
        chk("midreq_req", 32'(imem_bus.imem_req), 32'h0);
        chk("midreq_pc", pc_current, 32'h0);
        @(posedge clk); #1;
        imem_bus.imem_ack = 1'b0;
        chk("midreq_instr", instr, 32'h0);
        apply_reset();
        do_fetch(0);
        chk("restart_instr", instr, 32'h0000_0013);

        // Misaligned jalr target.
        retire(32'h4, '0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_trap", 32'(misalign_trap), 32'h1);
        chk("mis_halted", 32'(halted), 32'h1);
        chk("mis_pc", pc_current, 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        apply_reset();
`else
        chk("mis_align_addr", imem_bus.imem_addr, 32'h100);
`endif
        do_fetch(0);

        // Halt on HOLD exit; stray acks must be ignored afterwards.
        retire(32'h104, '0, 1'b0, 1'b0, '0, 1'b1);
        repeat (4) begin
            imem_bus.imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_bus.imem_ack = 1'b0;
        end
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_req", 32'(imem_bus.imem_req), 32'h0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
